// File: rtl/oled_spi_rx_if.sv
// ---------------------------------------------------------------------------
// oled_spi_rx_if
// Bundles the 4-wire OLED SPI pins and the receiver's decoded outputs.
//   master : drives sck/mosi/cs/dc, observes every receiver output
//   slave  : the receiver (oled_spi_rx) side
// Signals:
//   sck, mosi, cs, dc        SPI pins (mode 0, MSB first, cs active low)
//   rx_valid/rx_byte/rx_dc   raw deserialised byte and its dc tag
//   frame_err                cs released with a partial byte pending
//   cmd_valid/cmd_byte       command or argument byte accepted
//   gram_we/gram_page/gram_col/gram_wdata  GRAM write strobe with address
//   display_on               panel on/off state
// ---------------------------------------------------------------------------
interface oled_spi_rx_if;
    logic       sck;
    logic       mosi;
    logic       cs;
    logic       dc;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_dc;
    logic       frame_err;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       gram_we;
    logic [2:0] gram_page;
    logic [6:0] gram_col;
    logic [7:0] gram_wdata;
    logic       display_on;

    modport master (
        output sck, mosi, cs, dc,
        input  rx_valid, rx_byte, rx_dc, frame_err, cmd_valid, cmd_byte,
        input  gram_we, gram_page, gram_col, gram_wdata, display_on
    );

    modport slave (
        input  sck, mosi, cs, dc,
        output rx_valid, rx_byte, rx_dc, frame_err, cmd_valid, cmd_byte,
        output gram_we, gram_page, gram_col, gram_wdata, display_on
    );
endinterface

// File: rtl/oled_spi_rx.sv
// ---------------------------------------------------------------------------
// oled_spi_rx
// SSD1306-class receiving end of the 4-wire OLED SPI link. The SPI pins are
// oversampled by clk, bytes are deserialised and tagged with dc, command
// bytes drive a small addressing decoder and data bytes become GRAM write
// strobes with the current (page, column) before the pointer advances.
// Ports:
//   clk      system clock, all logic on rising edge
//   reset_n  synchronous active-low reset
//   bus      oled_spi_rx_if.slave (SPI pins in, decoded outputs out)
// ---------------------------------------------------------------------------
module oled_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 128,
    parameter int PAGES       = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    oled_spi_rx_if.slave   bus
);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    typedef enum logic [2:0] {
        IDLE, ARG_MODE, ARG_COL_S, ARG_COL_E, ARG_PAGE_S, ARG_PAGE_E, ARG_SKIP
    } state_t;

    // pin synchronisers: oldest sample at the top index
    logic [SYNC_STAGES-1:0] sck_sync_r, mosi_sync_r, cs_sync_r, dc_sync_r;
    logic                   sck_prev_r, cs_prev_r;
    logic [2:0]             bit_cnt_r;
    logic [6:0]             shift_r;
    logic                   rx_valid_r, rx_dc_r, frame_err_r;
    logic [7:0]             rx_byte_r;

    logic                   sck_s, mosi_s, cs_s, dc_s;
    logic                   sck_rise_s, cs_rise_s, cs_fall_s;

    state_t                 state_r;
    logic [CW-1:0]          col_r, col_s_r, col_e_r;
    logic [PW-1:0]          page_r, page_s_r, page_e_r;
    logic [1:0]             mode_r;
    logic                   cmd_valid_r, gram_we_r, display_on_r;
    logic [7:0]             cmd_byte_r, gram_wdata_r;
    logic [CW-1:0]          gram_col_r;
    logic [PW-1:0]          gram_page_r;

    // column pointer wraps at the window end or the last physical column
    function automatic logic col_wrap(input logic [CW-1:0] c, input logic [CW-1:0] ce);
        return (c == ce) || (c == CW'(COLS - 1));
    endfunction

    function automatic logic page_wrap(input logic [PW-1:0] p, input logic [PW-1:0] pe);
        return (p == pe) || (p == PW'(PAGES - 1));
    endfunction

    function automatic logic [CW-1:0] col_adv(input logic [CW-1:0] c,
                                              input logic [CW-1:0] cs_v,
                                              input logic [CW-1:0] ce);
        return col_wrap(c, ce) ? cs_v : c + CW'(1);
    endfunction

    function automatic logic [PW-1:0] page_adv(input logic [PW-1:0] p,
                                               input logic [PW-1:0] ps_v,
                                               input logic [PW-1:0] pe);
        return page_wrap(p, pe) ? ps_v : p + PW'(1);
    endfunction

    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign cs_s       = cs_sync_r[SYNC_STAGES-1];
    assign dc_s       = dc_sync_r[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_r;
    assign cs_rise_s  = cs_s & ~cs_prev_r;
    assign cs_fall_s  = ~cs_s & cs_prev_r;

    // synchroniser chains and edge-detect history
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sck_sync_r  <= '0;
            mosi_sync_r <= '0;
            cs_sync_r   <= '0;
            dc_sync_r   <= '0;
            sck_prev_r  <= 1'b0;
            cs_prev_r   <= 1'b0;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], bus.sck};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi};
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], bus.cs};
            dc_sync_r   <= {dc_sync_r[SYNC_STAGES-2:0], bus.dc};
            sck_prev_r  <= sck_s;
            cs_prev_r   <= cs_s;
        end
    end

    // byte shifter with cs framing; cs edges take priority over sck
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt_r   <= 3'd0;
            shift_r     <= 7'd0;
            rx_valid_r  <= 1'b0;
            rx_byte_r   <= 8'd0;
            rx_dc_r     <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (cs_rise_s) begin
                frame_err_r <= (bit_cnt_r != 3'd0);
                bit_cnt_r   <= 3'd0;
            end else if (cs_fall_s) begin
                bit_cnt_r <= 3'd0;
            end else if (!cs_s && sck_rise_s) begin
                shift_r   <= {shift_r[5:0], mosi_s};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    rx_valid_r <= 1'b1;
                    rx_byte_r  <= {shift_r, mosi_s};
                    rx_dc_r    <= dc_s;
                end else begin
                    rx_valid_r <= 1'b0;
                end
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // command decoder FSM and GRAM pointer engine, one cycle behind rx_valid
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            col_r        <= '0;
            col_s_r      <= '0;
            col_e_r      <= CW'(COLS - 1);
            page_r       <= '0;
            page_s_r     <= '0;
            page_e_r     <= PW'(PAGES - 1);
            mode_r       <= 2'd2;
            cmd_valid_r  <= 1'b0;
            cmd_byte_r   <= 8'd0;
            gram_we_r    <= 1'b0;
            gram_page_r  <= '0;
            gram_col_r   <= '0;
            gram_wdata_r <= 8'd0;
            display_on_r <= 1'b0;
        end else begin
            cmd_valid_r <= 1'b0;
            gram_we_r   <= 1'b0;
            if (rx_valid_r && rx_dc_r) begin
                // data abandons any pending argument
                state_r      <= IDLE;
                gram_we_r    <= 1'b1;
                gram_page_r  <= page_r;
                gram_col_r   <= col_r;
                gram_wdata_r <= rx_byte_r;
                case (mode_r)
                    2'd0: begin
                        col_r <= col_adv(col_r, col_s_r, col_e_r);
                        if (col_wrap(col_r, col_e_r)) begin
                            page_r <= page_adv(page_r, page_s_r, page_e_r);
                        end else begin
                            page_r <= page_r;
                        end
                    end
                    2'd1: begin
                        page_r <= page_adv(page_r, page_s_r, page_e_r);
                        if (page_wrap(page_r, page_e_r)) begin
                            col_r <= col_adv(col_r, col_s_r, col_e_r);
                        end else begin
                            col_r <= col_r;
                        end
                    end
                    default: col_r <= col_adv(col_r, col_s_r, col_e_r);
                endcase
            end else if (rx_valid_r) begin
                cmd_valid_r <= 1'b1;
                cmd_byte_r  <= rx_byte_r;
                case (state_r)
                    IDLE: begin
                        casez (rx_byte_r)
                            8'b0000_????: col_r[3:0] <= rx_byte_r[3:0];
                            8'b0001_0???: col_r[6:4] <= rx_byte_r[2:0];
                            8'b1011_0???: page_r     <= rx_byte_r[PW-1:0];
                            8'hAE, 8'hAF: display_on_r <= rx_byte_r[0];
                            8'h20: state_r <= ARG_MODE;
                            8'h21: state_r <= ARG_COL_S;
                            8'h22: state_r <= ARG_PAGE_S;
                            8'h81, 8'h8D, 8'hA8, 8'hD3,
                            8'hD5, 8'hD9, 8'hDA, 8'hDB: state_r <= ARG_SKIP;
                            default: state_r <= IDLE;
                        endcase
                    end
                    ARG_MODE: begin
                        mode_r  <= (rx_byte_r[1:0] == 2'd3) ? 2'd2 : rx_byte_r[1:0];
                        state_r <= IDLE;
                    end
                    ARG_COL_S: begin
                        col_s_r <= rx_byte_r[CW-1:0];
                        col_r   <= rx_byte_r[CW-1:0];
                        state_r <= ARG_COL_E;
                    end
                    ARG_COL_E: begin
                        col_e_r <= rx_byte_r[CW-1:0];
                        state_r <= IDLE;
                    end
                    ARG_PAGE_S: begin
                        page_s_r <= rx_byte_r[PW-1:0];
                        page_r   <= rx_byte_r[PW-1:0];
                        state_r  <= ARG_PAGE_E;
                    end
                    ARG_PAGE_E: begin
                        page_e_r <= rx_byte_r[PW-1:0];
                        state_r  <= IDLE;
                    end
                    default: state_r <= IDLE;
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

    assign bus.rx_valid   = rx_valid_r;
    assign bus.rx_byte    = rx_byte_r;
    assign bus.rx_dc      = rx_dc_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.cmd_valid  = cmd_valid_r;
    assign bus.cmd_byte   = cmd_byte_r;
    assign bus.gram_we    = gram_we_r;
    assign bus.gram_page  = gram_page_r;
    assign bus.gram_col   = gram_col_r;
    assign bus.gram_wdata = gram_wdata_r;
    assign bus.display_on = display_on_r;
endmodule
